// File: rtl/wait_state_ram_pkg.sv
// Shared encodings for the wait-state RAM: access sizes, FSM states and the
// wait-counter width helper.
package wait_state_ram_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    // Counter only ever reaches LATENCY-1, but keep at least one bit for LATENCY=0.
    function automatic int unsigned cnt_width(input int unsigned latency);
        int unsigned w;
        w = $clog2(latency + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ram_lane_steer.sv
// Combinational size/alignment decode: fault detection, big-endian byte lane
// enables for writes and sign/zero extension of read data.
module ram_lane_steer
    import wait_state_ram_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        se_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_raw_i,
    output logic        fault_o,
    output logic [3:0]  we_o,
    output logic [31:0] wbytes_o,
    output logic [31:0] rdata_o
);

    // Lane k (bit k of we_o, bits [31-8k -: 8] of the byte buses) is Address+k.
    always_comb begin
        fault_o  = 1'b0;
        we_o     = 4'b0000;
        wbytes_o = 32'h0;
        rdata_o  = 32'h0;
        case (size_i)
            BYTE: begin
                we_o     = 4'b0001;
                wbytes_o = {wdata_i[7:0], 24'h0};
                rdata_o  = {{24{se_i & rdata_raw_i[31]}}, rdata_raw_i[31:24]};
            end
            HALF: begin
                fault_o  = addr_lo_i[0];
                we_o     = 4'b0011;
                wbytes_o = {wdata_i[15:0], 16'h0};
                rdata_o  = {{16{se_i & rdata_raw_i[31]}}, rdata_raw_i[31:16]};
            end
            WORD: begin
                fault_o  = (addr_lo_i != 2'b00);
                we_o     = 4'b1111;
                wbytes_o = wdata_i;
                rdata_o  = rdata_raw_i;
            end
            RSVD:    fault_o = 1'b1;
            default: fault_o = 1'b1;
        endcase
        if (fault_o) begin
            we_o    = 4'b0000;
            rdata_o = 32'h0;
        end
    end

endmodule

// File: rtl/wait_state_ram.sv
// Byte-addressed big-endian RAM with a configurable number of wait states and
// a four-phase MOV/MOC handshake.
module wait_state_ram
    import wait_state_ram_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        m,
    input  logic              SE,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              Fault
);

    localparam int unsigned CntW = cnt_width(LATENCY);
    localparam logic [CntW-1:0] LastCnt = CntW'((LATENCY > 0) ? LATENCY - 1 : 0);

    logic [7:0] Memory [DEPTH];

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    size_e             size_q, size_d;
    logic              rw_q, rw_d;
    logic              se_q, se_d;
    logic              moc_q, moc_d;
    logic              fault_q, fault_d;
    logic [31:0]       dout_q, dout_d;

    logic [ADDR_W-1:0] lane_addr [4];
    logic [31:0]       rbytes;
    logic              fault;
    logic [3:0]        we;
    logic [31:0]       wbytes;
    logic [31:0]       rdata;
    logic              do_access;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = addr_q + ADDR_W'(k);
        end
    end

    assign rbytes = {Memory[lane_addr[0]], Memory[lane_addr[1]],
                     Memory[lane_addr[2]], Memory[lane_addr[3]]};

    ram_lane_steer u_steer (
        .size_i      (size_q),
        .addr_lo_i   (addr_q[1:0]),
        .se_i        (se_q),
        .wdata_i     (din_q),
        .rdata_raw_i (rbytes),
        .fault_o     (fault),
        .we_o        (we),
        .wbytes_o    (wbytes),
        .rdata_o     (rdata)
    );

    // The access happens on the edge that raises MOC, so a reset that lands
    // before completion leaves Memory untouched.
    assign do_access = (state_q == DONE) && !moc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        size_d  = size_q;
        rw_d    = rw_q;
        se_d    = se_q;
        moc_d   = moc_q;
        fault_d = fault_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (MOV) begin
                    addr_d  = Address;
                    din_d   = DataIn;
                    size_d  = size_e'(m);
                    rw_d    = RW;
                    se_d    = SE;
                    cnt_d   = '0;
                    state_d = (LATENCY > 0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (cnt_q == LastCnt) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (!moc_q) begin
                    moc_d   = 1'b1;
                    fault_d = fault;
                    if (fault) begin
                        dout_d = 32'h0;
                    end else if (rw_q) begin
                        dout_d = rdata;
                    end
                end else if (!MOV) begin
                    moc_d   = 1'b0;
                    fault_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= 32'h0;
            size_q  <= BYTE;
            rw_q    <= 1'b0;
            se_q    <= 1'b0;
            moc_q   <= 1'b0;
            fault_q <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            se_q    <= se_d;
            moc_q   <= moc_d;
            fault_q <= fault_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_access && !rw_q) begin
            for (int k = 0; k < 4; k++) begin
                if (we[k]) begin
                    Memory[lane_addr[k]] <= wbytes[31-8*k -: 8];
                end
            end
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign Fault   = fault_q;

endmodule

// File: tb/tb_wait_state_ram.sv
// Scoreboard bench: two RAM instances (2 and 0 wait states) share one request
// stream; per-instance monitors pop expected responses whenever MOC rises.
module tb_wait_state_ram;

    localparam int unsigned LAT_A = 2;
    localparam int unsigned LAT_B = 0;

    typedef struct packed {
        logic [31:0] dout;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mov = 1'b0;
    logic        rw  = 1'b0;
    logic        se  = 1'b0;
    logic [1:0]  m   = 2'b00;
    logic [7:0]  addr = 8'h0;
    logic [31:0] din  = 32'h0;
    logic [31:0] dout_a, dout_b;
    logic        moc_a, moc_b, fault_a, fault_b;

    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        held_a, held_b;
    logic        prev_a = 1'b0;
    logic        prev_b = 1'b0;
    int          checks = 0;
    int          errors = 0;
    time         acc_t  = 0;
    logic [31:0] last_dout = 32'h0;

    always #5 clk = ~clk;

    wait_state_ram #(.DEPTH(256), .ADDR_W(8), .LATENCY(LAT_A)) dut_a (
        .CLK(clk), .reset(rst), .MOV(mov), .RW(rw), .m(m), .SE(se), .Address(addr),
        .DataIn(din), .DataOut(dout_a), .MOC(moc_a), .Fault(fault_a)
    );

    wait_state_ram #(.DEPTH(256), .ADDR_W(8), .LATENCY(LAT_B)) dut_b (
        .CLK(clk), .reset(rst), .MOV(mov), .RW(rw), .m(m), .SE(se), .Address(addr),
        .DataIn(din), .DataOut(dout_b), .MOC(moc_b), .Fault(fault_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        if (moc_a && !prev_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_moc: got 1 expected 0");
            end else begin
                held_a = q_a.pop_front();
                check("a_dout", dout_a, held_a.dout);
                check("a_fault", {31'h0, fault_a}, {31'h0, held_a.fault});
                check("a_latency", 32'(($time - acc_t - 5) / 10), LAT_A + 1);
            end
        end else if (moc_a && prev_a) begin
            check("a_hold_dout", dout_a, held_a.dout);
            check("a_hold_fault", {31'h0, fault_a}, {31'h0, held_a.fault});
        end
        prev_a = moc_a;
    end

    always @(negedge clk) begin : mon_b
        if (moc_b && !prev_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_moc: got 1 expected 0");
            end else begin
                held_b = q_b.pop_front();
                check("b_dout", dout_b, held_b.dout);
                check("b_fault", {31'h0, fault_b}, {31'h0, held_b.fault});
                check("b_latency", 32'(($time - acc_t - 5) / 10), LAT_B + 1);
            end
        end else if (moc_b && prev_b) begin
            check("b_hold_dout", dout_b, held_b.dout);
            check("b_hold_fault", {31'h0, fault_b}, {31'h0, held_b.fault});
        end
        prev_b = moc_b;
    end

    // One full handshake; inputs are scrambled right after the accept edge.
    task automatic op(input logic r, input logic [1:0] mm, input logic s, input logic [7:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_f,
                      input int hold);
        exp_t e;
        int   n;
        e.fault = exp_f;
        e.dout  = exp_f ? 32'h0 : (r ? exp_rd : last_dout);
        last_dout = e.dout;
        q_a.push_back(e);
        q_b.push_back(e);
        @(negedge clk);
        rw = r; m = mm; se = s; addr = a; din = d; mov = 1'b1;
        @(posedge clk);
        acc_t = $time;
        #1;
        rw = ~r; m = ~mm; se = ~s; addr = ~a; din = ~d;
        n = 0;
        while (!(moc_a && moc_b) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            checks++;
            errors++;
            $display("FAIL moc_timeout: got %b%b expected 11", moc_a, moc_b);
        end
        repeat (hold) @(negedge clk);
        mov = 1'b0;
        @(negedge clk);
        check("moc_a_drop", {31'h0, moc_a}, 32'h0);
        check("moc_b_drop", {31'h0, moc_b}, 32'h0);
        repeat (2) @(negedge clk);
        check("moc_idle", {30'h0, moc_a, moc_b}, 32'h0);
    endtask

    task automatic mem_chk(input logic [7:0] a, input logic [7:0] exp);
        check($sformatf("mem_a[%h]", a), {24'h0, dut_a.Memory[a]}, {24'h0, exp});
        check($sformatf("mem_b[%h]", a), {24'h0, dut_b.Memory[a]}, {24'h0, exp});
    endtask

    task automatic idle_chk(input string name);
        check({name, "_moc"}, {30'h0, moc_a, moc_b}, 32'h0);
        check({name, "_fault"}, {30'h0, fault_a, fault_b}, 32'h0);
        check({name, "_dout_a"}, dout_a, 32'h0);
        check({name, "_dout_b"}, dout_b, 32'h0);
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        idle_chk("reset");
        rst = 1'b0;

        // Word write/read, big-endian byte order.
        op(1'b0, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        mem_chk(8'h10, 8'hDE);
        mem_chk(8'h11, 8'hAD);
        mem_chk(8'h12, 8'hBE);
        mem_chk(8'h13, 8'hEF);
        op(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        // Byte with sign bit set, upper write data ignored.
        op(1'b0, 2'b00, 1'b0, 8'h21, 32'h12345680, 32'h0, 1'b0, 0);
        mem_chk(8'h21, 8'h80);
        op(1'b1, 2'b00, 1'b1, 8'h21, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        op(1'b1, 2'b00, 1'b0, 8'h21, 32'h0, 32'h00000080, 1'b0, 0);

        // Faults: misaligned half/word, reserved size, reserved-size write.
        op(1'b1, 2'b01, 1'b0, 8'h03, 32'h0, 32'h0, 1'b1, 0);
        op(1'b1, 2'b10, 1'b0, 8'h02, 32'h0, 32'h0, 1'b1, 0);
        op(1'b1, 2'b11, 1'b0, 8'h10, 32'h0, 32'h0, 1'b1, 0);
        op(1'b0, 2'b11, 1'b0, 8'h10, 32'h01020304, 32'h0, 1'b1, 0);
        mem_chk(8'h10, 8'hDE);
        mem_chk(8'h11, 8'hAD);

        // A write after a read leaves DataOut holding the read value.
        op(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        op(1'b0, 2'b01, 1'b0, 8'h30, 32'h55558001, 32'h0, 1'b0, 0);
        op(1'b1, 2'b01, 1'b1, 8'h30, 32'h0, 32'hFFFF8001, 1'b0, 0);
        op(1'b1, 2'b01, 1'b0, 8'h30, 32'h0, 32'h00008001, 1'b0, 0);

        // Top of memory.
        op(1'b0, 2'b00, 1'b0, 8'hFC, 32'h000000AB, 32'h0, 1'b0, 0);
        op(1'b0, 2'b00, 1'b0, 8'hFD, 32'h000000CD, 32'h0, 1'b0, 0);
        op(1'b0, 2'b01, 1'b0, 8'hFE, 32'hFFFF1234, 32'h0, 1'b0, 0);
        mem_chk(8'hFE, 8'h12);
        mem_chk(8'hFF, 8'h34);
        op(1'b1, 2'b10, 1'b0, 8'hFC, 32'h0, 32'hABCD1234, 1'b0, 0);
        op(1'b1, 2'b01, 1'b1, 8'hFE, 32'h0, 32'h00001234, 1'b0, 0);

        // MOV held 5 cycles past MOC.
        op(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);

        // Reset aborts an in-flight write.
        op(1'b0, 2'b10, 1'b0, 8'h40, 32'h11223344, 32'h0, 1'b0, 0);
        @(negedge clk);
        rw = 1'b0; m = 2'b10; se = 1'b0; addr = 8'h40; din = 32'hAAAAAAAA; mov = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        mov = 1'b0;
        #1 check("abort_moc", {30'h0, moc_a, moc_b}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_dout = 32'h0;
        idle_chk("abort");
        mem_chk(8'h40, 8'h11);
        mem_chk(8'h41, 8'h22);
        mem_chk(8'h42, 8'h33);
        mem_chk(8'h43, 8'h44);
        op(1'b1, 2'b10, 1'b0, 8'h40, 32'h0, 32'h11223344, 1'b0, 0);

        check("q_a_left", q_a.size(), 32'h0);
        check("q_b_left", q_b.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wait_state_ram.md
WAIT_STATE_RAM -- requirements
Module: wait_state_ram

Interface
REQ-001 Parameter DEPTH, default 256, meaning memory size in bytes (power of two).
REQ-002 Parameter ADDR_W, default 8, meaning address width; DEPTH = 2**ADDR_W.
REQ-003 Parameter LATENCY, default 2, meaning wait cycles inserted before completion (0 allowed).
REQ-004 CLK  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 MOV  input  1  memory operation valid; held high by requester until MOC seen.
REQ-007 RW  input  1  1 = read, 0 = write.
REQ-008 m  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 SE  input  1  sign-extend byte/halfword reads when 1, zero-extend when 0.
REQ-010 Address  input  ADDR_W  byte address.
REQ-011 DataIn  input  32  write data, right-justified for byte/halfword.
REQ-012 DataOut  output  32  read data, registered.
REQ-013 MOC  output  1  memory operation complete.
REQ-014 Fault  output  1  alignment/mode fault, valid while MOC high.

Function
REQ-015 Storage SHALL be an array named Memory of DEPTH 8-bit bytes, big-endian (lowest address = most significant byte).
REQ-016 FSM states SHALL be IDLE, WAIT, DONE.
REQ-017 In IDLE with MOV=1, block SHALL latch Address, DataIn, m, RW, SE and enter WAIT (LATENCY>0) or DONE (LATENCY=0).
REQ-018 WAIT SHALL count LATENCY cycles, then perform the access and enter DONE.
REQ-019 MOC SHALL rise exactly LATENCY+1 cycles after the edge on which MOV was sampled high in IDLE.
REQ-020 DONE SHALL hold MOC=1, DataOut and Fault stable until MOV=0 sampled, then return to IDLE with MOC=0 next cycle (four-phase handshake).
REQ-021 Input changes after the accept edge SHALL NOT affect the in-flight operation.
REQ-022 A new operation SHALL NOT be accepted until MOC has returned to 0 (MOV high on the cycle after IDLE re-entry starts a new access).
REQ-023 Fault SHALL be 1 for m=11, m=01 with Address[0]=1, or m=10 with Address[1:0]!=00; otherwise 0.
REQ-024 A faulting access SHALL still complete the handshake, SHALL NOT write Memory, and SHALL return DataOut=0.
REQ-025 Writes SHALL store DataIn[7:0] (byte), DataIn[15:0] (halfword), DataIn[31:0] (word) at Address..Address+n-1.
REQ-026 Reads SHALL place the value in DataOut low bits, upper bits filled by SE rule; word reads ignore SE.
REQ-027 Byte addresses Address+k SHALL wrap modulo DEPTH.
REQ-028 DataOut SHALL update only on read completion; writes leave DataOut unchanged.

Reset
REQ-029 reset=1 SHALL asynchronously force state IDLE, MOC=0, Fault=0, DataOut=0, wait counter 0.
REQ-030 reset during WAIT SHALL abort the operation with no Memory write.
REQ-031 Memory contents SHALL NOT be cleared by reset (testbench preloads via hierarchy).

Structure
REQ-032 Shared package SHALL hold size encodings (BYTE, HALF, WORD, RSVD) and the FSM state enum.
REQ-033 Wait-cycle counter SHALL be $clog2(LATENCY+1) bits, minimum 1.
REQ-034 One sub-module, ram_lane_steer (combinational: size/alignment check, fault, sign/zero extension), is natural; FSM and array stay in top.

Verification
REQ-035 LATENCY=2: write word 0xDEADBEEF at 0x10, read back -> MOC rises 3 cycles after accept, DataOut=0xDEADBEEF, Memory[0x10]=0xDE, Memory[0x13]=0xEF.
REQ-036 Byte 0x80 at 0x21: read SE=1 -> 0xFFFFFF80; SE=0 -> 0x00000080.
REQ-037 Halfword read at 0x03, word at 0x02, m=11 -> Fault=1, DataOut=0, Memory unchanged, handshake completes.
REQ-038 LATENCY=0, DEPTH=256: halfword write 0x1234 at 0xFE -> MOC next cycle, Memory[0xFE]=0x12, Memory[0xFF]=0x34; then word read at 0xFC returns bytes FC..FF.
REQ-039 Assert reset one cycle into WAIT of a write of 0xAAAAAAAA at 0x40 -> MOC=0 immediately, Memory[0x40..0x43] unchanged, next MOV accepted normally.
REQ-040 Hold MOV high 5 cycles after MOC: MOC, DataOut stay stable; drop MOV -> MOC=0 one cycle later, no second access.
